// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides, registered flags,
// a sticky overflow bit and a delivered-result counter.
module alu_pipe #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               ovf,
  output logic               carry,
  output logic               zero,
  output logic               neg,
  output logic               sticky_ovf,
  input  logic               sticky_clr,
  output logic [COUNT_W-1:0] res_count
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_XOR  = 3'd2,
    OP_SLT  = 3'd3,
    OP_AND  = 3'd4,
    OP_NAND = 3'd5,
    OP_NOR  = 3'd6,
    OP_OR   = 3'd7
  } op_e;

  logic               s1Valid_q, s1Valid_d;
  op_e                s1Op_q, s1Op_d;
  logic [WIDTH-1:0]   s1A_q, s1A_d, s1B_q, s1B_d;
  logic               s2Valid_q, s2Valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d, carry_q, carry_d, zero_q, zero_d, neg_q, neg_d;
  logic               sticky_q, sticky_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic               s2Adv, accept, deliver;
  logic [WIDTH:0]     sumExt, diffExt;
  logic               ovfAdd, ovfSub;
  logic [WIDTH-1:0]   aluRes;
  logic               aluOvf, aluCarry;

  assign s2Adv     = !s2Valid_q || out_ready;
  assign in_ready  = !s1Valid_q || s2Adv;
  assign accept    = in_valid && in_ready;
  assign deliver   = s2Valid_q && out_ready;
  assign out_valid = s2Valid_q;

  // Both the sum and the difference are always formed; SLT reuses the subtract
  // so its sign is corrected by the subtract overflow.
  always_comb begin
    sumExt   = {1'b0, s1A_q} + {1'b0, s1B_q};
    diffExt  = {1'b0, s1A_q} - {1'b0, s1B_q};
    ovfAdd   = (s1A_q[WIDTH-1] == s1B_q[WIDTH-1]) && (sumExt[WIDTH-1] != s1A_q[WIDTH-1]);
    ovfSub   = (s1A_q[WIDTH-1] != s1B_q[WIDTH-1]) && (diffExt[WIDTH-1] != s1A_q[WIDTH-1]);
    aluRes   = '0;
    aluOvf   = 1'b0;
    aluCarry = 1'b0;
    unique case (s1Op_q)
      OP_ADD: begin
        aluRes   = sumExt[WIDTH-1:0];
        aluOvf   = ovfAdd;
        aluCarry = sumExt[WIDTH];
      end
      OP_SUB: begin
        aluRes   = diffExt[WIDTH-1:0];
        aluOvf   = ovfSub;
        aluCarry = !diffExt[WIDTH];
      end
      OP_XOR:  aluRes = s1A_q ^ s1B_q;
      OP_SLT:  aluRes = {{(WIDTH-1){1'b0}}, diffExt[WIDTH-1] ^ ovfSub};
      OP_AND:  aluRes = s1A_q & s1B_q;
      OP_NAND: aluRes = ~(s1A_q & s1B_q);
      OP_NOR:  aluRes = ~(s1A_q | s1B_q);
      OP_OR:   aluRes = s1A_q | s1B_q;
      default: aluRes = '0;
    endcase
  end

  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Op_d    = s1Op_q;
    s1A_d     = s1A_q;
    s1B_d     = s1B_q;
    s2Valid_d = s2Valid_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    sticky_d  = sticky_q;
    count_d   = count_q + COUNT_W'(deliver);

    if (accept) begin
      s1Valid_d = 1'b1;
      s1Op_d    = op_e'(op);
      s1A_d     = a;
      s1B_d     = b;
    end else if (s2Adv) begin
      s1Valid_d = 1'b0;
    end

    if (s2Adv) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        result_d = aluRes;
        ovf_d    = aluOvf;
        carry_d  = aluCarry;
        zero_d   = (aluRes == '0);
        neg_d    = aluRes[WIDTH-1];
      end
    end

    // A new overflow in the same cycle as a clear request keeps the flag set.
    if (s2Adv && s1Valid_q && aluOvf) begin
      sticky_d = 1'b1;
    end else if (sticky_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1Valid_q <= 1'b0;
      s1Op_q    <= OP_ADD;
      s1A_q     <= '0;
      s1B_q     <= '0;
      s2Valid_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      sticky_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Op_q    <= s1Op_d;
      s1A_q     <= s1A_d;
      s1B_q     <= s1B_d;
      s2Valid_q <= s2Valid_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      neg_q     <= neg_d;
      sticky_q  <= sticky_d;
      count_q   <= count_d;
    end
  end

  assign result     = result_q;
  assign ovf        = ovf_q;
  assign carry      = carry_q;
  assign zero       = zero_q;
  assign neg        = neg_q;
  assign sticky_ovf = sticky_q;
  assign res_count  = count_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed scenarios plus randomized traffic, checked every cycle
// against an in-order queue model of the ALU rules.
module tb_alu_pipe;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          ovf, carry, zero, neg;
  logic          sticky_ovf;
  logic          sticky_clr;
  logic [CW-1:0] res_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   expCount  = 0;
  logic expSticky = 1'b0;

  alu_pipe #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .carry(carry), .zero(zero), .neg(neg),
    .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr), .res_count(res_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU in plain 64-bit signed/unsigned arithmetic.
  function automatic exp_t aluModel(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint ux, uy, sx, sy, full, s;
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.c = 1'b0;
    e.v = 1'b0;
    e.acc = 0;
    case (o)
      3'd0: begin
        full = ux + uy;
        e.r  = full[31:0];
        e.c  = full[32];
        s    = sx + sy;
        e.v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        full = ux - uy;
        e.r  = full[31:0];
        e.c  = (ux >= uy);
        s    = sx - sy;
        e.v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: e.r = x ^ y;
      3'd3: e.r = (sx < sy) ? 32'd1 : 32'd0;
      3'd4: e.r = x & y;
      3'd5: e.r = ~(x & y);
      3'd6: e.r = ~(x | y);
      default: e.r = x | y;
    endcase
    e.z = (e.r == 32'd0);
    e.n = e.r[31];
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic ordy, input logic clr);
    in_valid   = v;
    op         = o;
    a          = x;
    b          = y;
    out_ready  = ordy;
    sticky_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_count", 32'(res_count), 32'd0);
    checkOutput("rst_sticky", 32'(sticky_ovf), 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_flags", {28'd0, ovf, carry, zero, neg}, 32'd0);
    q.delete();
    expCount  = 0;
    expSticky = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Per-cycle compare against the queue model; also advances the model.
  always @(negedge clk) begin
    if (reset_n) begin
      logic occupied, expInReady, willLoad;
      int   w;
      occupied   = (q.size() > 0) && (cyc >= q[0].acc + 2);
      expInReady = (q.size() < 2) || out_ready;
      checkOutput("in_ready", 32'(in_ready), 32'(expInReady));
      checkOutput("out_valid", 32'(out_valid), 32'(occupied));
      if (occupied) begin
        checkOutput("result", result, q[0].r);
        checkOutput("flags", {28'd0, q[0].v, q[0].c, q[0].z, q[0].n},
                    {28'd0, ovf, carry, zero, neg});
      end
      checkOutput("res_count", 32'(res_count), 32'(expCount));
      checkOutput("sticky_ovf", 32'(sticky_ovf), 32'(expSticky));

      w        = occupied ? 1 : 0;
      willLoad = (q.size() > w) && (!occupied || out_ready);
      if (willLoad && q[w].v) expSticky = 1'b1;
      else if (sticky_clr)    expSticky = 1'b0;
      if (occupied && out_ready) begin
        void'(q.pop_front());
        expCount = (expCount + 1) % (1 << CW);
      end
      if (in_valid && expInReady) begin
        exp_t e;
        e     = aluModel(op, a, b);
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 7));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    exp_t m;
    reset_n = 1'b0;
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);

    m = aluModel(3'd0, 32'h8000_0288, 32'd1);
    checkOutput("model_add_neg", m.r, 32'h8000_0289);
    m = aluModel(3'd0, 32'h7FFF_FFFF, 32'd1);
    checkOutput("model_add_ovf", 32'(m.v), 32'd1);
    m = aluModel(3'd3, 32'h8000_0000, 32'd1);
    checkOutput("model_slt", m.r, 32'd1);
    m = aluModel(3'd1, 32'd5, 32'd5);
    checkOutput("model_sub_carry", {30'd0, m.c, m.z}, 32'd3);

    #12;
    doReset();
    step();

    // -2147483000 + 1 : two cycles to out_valid
    applyStimulus(1'b1, 3'd0, 32'h8000_0288, 32'd1, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    checkOutput("add_neg_valid", 32'(out_valid), 32'd1);
    checkOutput("add_neg_result", result, 32'h8000_0289);
    checkOutput("add_neg_flags", {30'd0, zero, neg}, 32'd1);

    applyStimulus(1'b1, 3'd0, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    checkOutput("add_ovf_result", result, 32'h8000_0000);
    checkOutput("add_ovf_flag", 32'(ovf), 32'd1);
    checkOutput("sticky_set", 32'(sticky_ovf), 32'd1);
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    checkOutput("sticky_cleared", 32'(sticky_ovf), 32'd0);

    applyStimulus(1'b1, 3'd3, 32'h8000_0000, 32'd1, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 3'd1, 32'd5, 32'd5, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    checkOutput("slt_ovf_result", result, 32'd1);
    step();
    checkOutput("sub_eq_result", result, 32'd0);
    checkOutput("sub_eq_flags", {30'd0, zero, carry}, 32'd3);
    step();

    // backpressure: two accepts then stall, then drain in order
    doReset();
    step();
    applyStimulus(1'b1, 3'd0, 32'd1, 32'd1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 3'd0, 32'd2, 32'd2, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 3'd0, 32'd3, 32'd3, 1'b0, 1'b0);
    checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
    step();
    step();
    checkOutput("bp_hold_result", result, 32'd2);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_first", result, 32'd2);
    step();
    in_valid = 1'b0;
    checkOutput("bp_second", result, 32'd4);
    step();
    checkOutput("bp_third", result, 32'd6);
    step();
    checkOutput("bp_drained", 32'(out_valid), 32'd0);
    checkOutput("bp_count", 32'(res_count), 32'd3);

    // counter wrap at 2^CW results
    doReset();
    step();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 3'($urandom_range(0, 7)), 32'($urandom), 32'($urandom), 1'b1, 1'b0);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    checkOutput("wrap_count", 32'(res_count), 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pickOperand(),
                    pickOperand(), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      step();
    end
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
    repeat (4) step();

    // reset with two ops in flight, one of them overflowing
    applyStimulus(1'b1, 3'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b1, 3'd0, 32'd1, 32'd1, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    checkOutput("mid_sticky", 32'(sticky_ovf), 32'd1);
    checkOutput("mid_full", 32'(in_ready), 32'd0);
    doReset();
    step();
    step();
    checkOutput("post_rst_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
